// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: shared definitions for the CPU bus responder.
//   - Address-window constants for the CPU memory map.
//   - bus_win_t: decoded window of a CPU (or DMA) address.
//   - dma_state_t: OAM DMA sequencer states (used when NES_OAM_DMA_EN is defined).
//   - decode_win(): maps a 16-bit address onto a window. dma_en selects whether
//     the $4014 page register is part of the map.
package nes_bus_pkg;

    localparam logic [15:0] RAM_END  = 16'h1FFF;
    localparam logic [15:0] PPU_BASE = 16'h2000;
    localparam logic [15:0] PPU_END  = 16'h3FFF;
    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] PAD_REG  = 16'h4016;
    localparam logic [15:0] ROM_BASE = 16'h8000;

    typedef enum logic [2:0] {
        WIN_NONE,
        WIN_RAM,
        WIN_PPU,
        WIN_DMA,
        WIN_PAD,
        WIN_ROM
    } bus_win_t;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_ALIGN,
        DMA_RD,
        DMA_WR
    } dma_state_t;

    function automatic bus_win_t decode_win(input logic [15:0] a, input logic dma_en);
        if (a <= RAM_END)                   return WIN_RAM;
        if (a >= PPU_BASE && a <= PPU_END)  return WIN_PPU;
        if (dma_en && a == DMA_REG)         return WIN_DMA;
        if (a == PAD_REG)                   return WIN_PAD;
        if (a >= ROM_BASE)                  return WIN_ROM;
        return WIN_NONE;
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// oam_dma_engine: sprite-OAM DMA sequencer. Only instantiated when the
// NES_OAM_DMA_EN macro is defined.
//   clk, rst_n     : clock, synchronous active-low reset
//   start          : CPU write to $4014 this cycle (accepted only when idle)
//   start_page     : page byte written to $4014
//   fetch_data     : byte read back from the address on fetch_addr
//   halt           : high while a transfer is in progress (ALIGN/RD/WR)
//   fetch_addr     : {page, cnt} source address for the RD state
//   oam_addr/oam_wdata/oam_we : OAM write port, pulsed once per byte in WR
// One transfer is 1 alignment cycle + 256 x (RD, WR) = 513 halted cycles.
module oam_dma_engine
    import nes_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  start_page,
    input  logic [7:0]  fetch_data,
    output logic        halt,
    output logic [15:0] fetch_addr,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we
);

    dma_state_t state, state_nx;
    logic [7:0] page, page_nx;
    logic [7:0] cnt, cnt_nx;
    logic [7:0] hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= DMA_IDLE;
            page  <= 8'h00;
            cnt   <= 8'h00;
        end else begin
            state <= state_nx;
            page  <= page_nx;
            cnt   <= cnt_nx;
        end
    end

    // Holding register is pure data; it is always rewritten in RD before use.
    always_ff @(posedge clk) begin
        if (state == DMA_RD) begin
            hold <= fetch_data;
        end
    end

    always_comb begin
        state_nx = state;
        page_nx  = page;
        cnt_nx   = cnt;
        halt     = 1'b1;
        oam_we   = 1'b0;
        case (state)
            DMA_IDLE: begin
                halt = 1'b0;
                if (start) begin
                    page_nx  = start_page;
                    cnt_nx   = 8'h00;
                    state_nx = DMA_ALIGN;
                end
            end
            DMA_ALIGN: state_nx = DMA_RD;
            DMA_RD:    state_nx = DMA_WR;
            DMA_WR: begin
                oam_we   = 1'b1;
                cnt_nx   = cnt + 8'd1;
                state_nx = (cnt == 8'hFF) ? DMA_IDLE : DMA_RD;
            end
            default: state_nx = DMA_IDLE;
        endcase
    end

    assign fetch_addr = {page, cnt};
    assign oam_addr   = cnt;
    assign oam_wdata  = hold;

endmodule

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: CPU-side address decoder and responder for an NES-style bus.
//   clk, rst_n               : clock, synchronous active-low reset
//   addr, data, rw_n         : CPU bus (data is bidirectional, driven only on decoded reads)
//   cpu_halt                 : stalls the CPU while OAM DMA owns the bus
//   ppu_addr/ppu_wdata/ppu_we/ppu_re/ppu_rdata : PPU register window ($2000-$3FFF)
//   oam_addr/oam_wdata/oam_we: OAM write port fed by the DMA engine
//   pad_buttons              : live controller state, serialised through $4016
//   rom_addr/rom_rdata       : PRG-ROM window ($8000-$FFFF), asynchronous ROM
// Build option: define NES_OAM_DMA_EN to include the $4014 OAM DMA engine; without
// it $4014 is unmapped and cpu_halt/oam_* are tied low.
module cpu_bus_responder
    import nes_bus_pkg::*;
#(
    parameter int RAM_AW = 11,
    parameter int ROM_AW = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       addr,
    inout  wire  [7:0]        data,
    input  logic              rw_n,
    output logic              cpu_halt,
    output logic [2:0]        ppu_addr,
    output logic [7:0]        ppu_wdata,
    output logic              ppu_we,
    output logic              ppu_re,
    input  logic [7:0]        ppu_rdata,
    output logic [7:0]        oam_addr,
    output logic [7:0]        oam_wdata,
    output logic              oam_we,
    input  logic [7:0]        pad_buttons,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_rdata
);

    bus_win_t    cpu_win;
    logic        bus_rd;
    logic        bus_wr;
    logic [15:0] src_addr;
    logic [7:0]  ram [1 << RAM_AW];
    logic [7:0]  ram_rdata;
    logic        strobe;
    logic [7:0]  pad_sr;
    logic        data_oe;
    logic [7:0]  data_out;

`ifdef NES_OAM_DMA_EN
    localparam logic DMA_EN = 1'b1;

    logic [15:0] dma_addr;
    logic [7:0]  dma_rdata;
    logic        dma_start;

    assign dma_start = bus_wr && (cpu_win == WIN_DMA);

    // While halted the DMA engine owns the shared RAM/ROM read path.
    assign src_addr = cpu_halt ? dma_addr : addr;

    // DMA fetches see only RAM and ROM; anything else reads as $00.
    always_comb begin
        dma_rdata = 8'h00;
        if (dma_addr <= RAM_END) begin
            dma_rdata = ram_rdata;
        end else if (dma_addr >= ROM_BASE) begin
            dma_rdata = rom_rdata;
        end
    end

    oam_dma_engine u_dma (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (dma_start),
        .start_page (data),
        .fetch_data (dma_rdata),
        .halt       (cpu_halt),
        .fetch_addr (dma_addr),
        .oam_addr   (oam_addr),
        .oam_wdata  (oam_wdata),
        .oam_we     (oam_we)
    );
`else
    localparam logic DMA_EN = 1'b0;

    assign src_addr  = addr;
    assign cpu_halt  = 1'b0;
    assign oam_addr  = 8'h00;
    assign oam_wdata = 8'h00;
    assign oam_we    = 1'b0;
`endif

    assign cpu_win = decode_win(addr, DMA_EN);

    // A halted CPU neither reads nor writes anything through the responder.
    assign bus_rd = rw_n & ~cpu_halt;
    assign bus_wr = ~rw_n & ~cpu_halt;

    // RAM window is 8 KiB but only RAM_AW bits index the array: mirroring.
    assign ram_rdata = ram[src_addr[RAM_AW-1:0]];
    assign rom_addr  = src_addr[ROM_AW-1:0];

    always_ff @(posedge clk) begin
        if (bus_wr && cpu_win == WIN_RAM) begin
            ram[addr[RAM_AW-1:0]] <= data;
        end
    end

    always_comb begin
        data_oe  = 1'b0;
        data_out = 8'h00;
        if (bus_rd) begin
            case (cpu_win)
                WIN_RAM: begin data_oe = 1'b1; data_out = ram_rdata;          end
                WIN_PPU: begin data_oe = 1'b1; data_out = ppu_rdata;          end
                WIN_DMA: begin data_oe = 1'b1; data_out = 8'h00;              end
                WIN_PAD: begin data_oe = 1'b1; data_out = {7'b0, pad_sr[0]};  end
                WIN_ROM: begin data_oe = 1'b1; data_out = rom_rdata;          end
                default: ;
            endcase
        end
    end

    assign data = data_oe ? data_out : 8'hzz;

    assign ppu_addr  = addr[2:0];
    assign ppu_wdata = data;
    assign ppu_we    = rst_n & bus_wr & (cpu_win == WIN_PPU);
    assign ppu_re    = rst_n & bus_rd & (cpu_win == WIN_PPU);

    // Controller port: strobe high keeps reloading; each strobe-low read shifts
    // out one button and fills with 1 so reads past the 8th return 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            strobe <= 1'b0;
            pad_sr <= 8'hFF;
        end else begin
            if (bus_wr && cpu_win == WIN_PAD) begin
                strobe <= data[0];
            end
            if (strobe) begin
                pad_sr <= pad_buttons;
            end else if (bus_rd && cpu_win == WIN_PAD) begin
                pad_sr <= {1'b1, pad_sr[7:1]};
            end
        end
    end

endmodule

// File: doc/cpu_bus_responder.md
CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 SHALL have parameter RAM_AW, default 11, meaning internal work-RAM address width (2 KiB).
REQ-002 SHALL have parameter ROM_AW, default 15, meaning PRG-ROM window address width (32 KiB at $8000-$FFFF).
REQ-003 SHALL have port clk, input, 1, system clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port addr, input, 16, CPU bus address.
REQ-006 SHALL have port data, inout, 8, CPU data bus; driven by responder only on decoded reads.
REQ-007 SHALL have port rw_n, input, 1, 1 = CPU read, 0 = CPU write.
REQ-008 SHALL have port cpu_halt, output, 1, stalls CPU fetch while OAM DMA runs.
REQ-009 SHALL have ports ppu_addr (output, 3), ppu_wdata (output, 8), ppu_we (output, 1), ppu_re (output, 1) and ppu_rdata (input, 8), the PPU register window.
REQ-010 SHALL have ports oam_addr (output, 8), oam_wdata (output, 8) and oam_we (output, 1), the OAM write port.
REQ-011 SHALL have ports pad_buttons (input, 8, live controller state) and rom_addr (output, ROM_AW), plus rom_rdata (input, 8, asynchronous ROM data).

Function
REQ-012 SHALL decode addresses as follows:
- $0000-$1FFF: RAM, mirrored, index addr[RAM_AW-1:0].
- $2000-$3FFF: PPU, ppu_addr = addr[2:0].
- $4014: DMA page register.
- $4016: pad port.
- $8000-$FFFF: ROM.
- All other addresses: unmapped.
REQ-013 SHALL drive data combinationally (same cycle) when rw_n=1, cpu_halt=0 and the address is mapped; otherwise data SHALL be high-Z. Unmapped reads SHALL leave the bus high-Z.
REQ-014 SHALL source read data as: RAM via asynchronous read; PPU from ppu_rdata; $4016 as {7'b0, pad_sr[0]}; ROM from rom_rdata, with rom_addr = addr[ROM_AW-1:0].
REQ-015 SHALL write RAM at the rising edge when rw_n=0 and the RAM window is decoded; writes to ROM and unmapped addresses SHALL be ignored.
REQ-016 SHALL assert ppu_we (on writes) or ppu_re (on reads) combinationally for every cycle the PPU window is decoded, with ppu_wdata = data.
REQ-017 SHALL handle the pad shift register as follows:
- Write to $4016 latches strobe = data[0].
- While strobe=1, pad_sr SHALL reload from pad_buttons every cycle.
- Each cycle of a $4016 read with strobe=0, pad_sr SHALL shift right with a 1 fill; after 8 reads, further reads return 1.
REQ-018 SHALL run a DMA FSM with states IDLE, ALIGN, RD, WR:
- A write of P to $4014 in IDLE sets the page, clears cnt, and moves to ALIGN.
- ALIGN moves to RD.
- RD moves to WR.
- WR moves to RD while cnt≠255, or to IDLE after writing cnt=255.
REQ-019 SHALL assert cpu_halt in ALIGN, RD and WR: exactly 513 cycles, starting the cycle after the $4014 write and deasserting the cycle after the last oam_we.
REQ-020 SHALL in RD fetch byte {P, cnt} through the same decode as CPU reads (RAM or ROM; unmapped returns $00; PPU and pad are not accessed) into a holding register.
REQ-021 SHALL in WR assert oam_we for one cycle with oam_addr = cnt and oam_wdata = held byte, then increment cnt (8-bit).
REQ-022 SHALL while cpu_halt=1 ignore CPU bus writes, not drive data, and ignore $4014 writes.

Reset
REQ-023 SHALL on rst_n=0 at a rising edge set the FSM to IDLE and reset outputs/state to cpu_halt=0, oam_we=0, oam_addr=0, cnt=0, page=0, strobe=0, pad_sr=8'hFF; this SHALL abort any DMA in progress.
REQ-024 SHALL NOT reset RAM contents; ppu_we and ppu_re SHALL be 0 while rst_n=0.

Configuration
REQ-025 SHALL compile in the DMA FSM only when macro NES_OAM_DMA_EN is defined. Without it, $4014 SHALL be unmapped, cpu_halt, oam_we, oam_addr and oam_wdata SHALL be tied to 0, and no DMA state exists.

Structure
REQ-026 SHALL place address-window constants (RAM_END, PPU_BASE/END, DMA_REG, PAD_REG, ROM_BASE) and the DMA state enumeration in shared package nes_bus_pkg.
REQ-027 SHALL implement the DMA FSM as sub-module oam_dma_engine, instantiated under NES_OAM_DMA_EN.

Verification
REQ-028 SHALL cover: write $5A to $0005, then read $0805 and $1805 -> data=$5A on both (mirror).
REQ-029 SHALL cover: write $01 then $00 to $4016 with pad_buttons=$A5, then 9 reads of $4016 -> data[0] sequence 1,0,1,0,0,1,0,1,1.
REQ-030 SHALL cover: RAM $0200-$02FF preloaded with i^$FF, write $02 to $4014 -> cpu_halt high for 513 cycles; 256 oam_we pulses, oam_addr 0..255, oam_wdata i^$FF.
REQ-031 SHALL cover: rst_n low at DMA pulse 100 -> next cycle cpu_halt=0, oam_we=0, FSM IDLE; a new $4014 write restarts DMA from cnt=0.
REQ-032 SHALL cover: read $5000 and $2002 with ppu_rdata=$80 -> $5000 leaves data high-Z; $2002 drives $80 with ppu_re=1 and ppu_addr=2.
REQ-033 SHALL cover: build without NES_OAM_DMA_EN, write $4014 -> cpu_halt stays 0 and oam_we never asserts.
